// File: rtl/comp_buf_pkg.sv
// Shared types and helpers for the double-buffered compensation weight store.
package comp_buf_pkg;

    // Read-side drain state.
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } rd_state_e;

    // Linear entry index of (row, col) in a bank filled row-major.
    function automatic int col_idx(input int row, input int col, input int cols);
        return row * cols + col;
    endfunction

    // Index width that never collapses to zero bits.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/compensation_buffer_if.sv
// Load/drain bus between the pre-load unit, the buffer and the systolic array.
interface compensation_buffer_if
    import comp_buf_pkg::*;
#(
    parameter int SIZE = 8,
    parameter int CW   = 3,
    parameter int COLS = 3
);
    localparam int COL_W = idx_w(COLS);

    logic                 flush;
    logic                 wr_valid;
    logic                 wr_ready;
    logic [CW-1:0]        wr_data;
    logic                 rd_start;
    logic                 rd_busy;
    logic                 out_valid;
    logic [COL_W-1:0]     out_col;
    logic [SIZE*CW-1:0]   out_data;
    logic [1:0]           bank_full;

    modport master (
        output flush, wr_valid, wr_data, rd_start,
        input  wr_ready, rd_busy, out_valid, out_col, out_data, bank_full
    );

    modport slave (
        input  flush, wr_valid, wr_data, rd_start,
        output wr_ready, rd_busy, out_valid, out_col, out_data, bank_full
    );
endinterface

// File: rtl/comp_buf_bank.sv
// One weight bank: linear write port, column-gather read port (SIZE reads at stride COLS).
module comp_buf_bank
    import comp_buf_pkg::*;
#(
    parameter int SIZE   = 8,
    parameter int CW     = 3,
    parameter int COLS   = 3,
    parameter int DEPTH  = SIZE * COLS,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int COL_W  = idx_w(COLS)
) (
    input  logic               clk,
    input  logic               we,
    input  logic [ADDR_W-1:0]  waddr,
    input  logic [CW-1:0]      wdata,
    input  logic [COL_W-1:0]   rd_col,
    output logic [SIZE*CW-1:0] rd_word
);
    logic [CW-1:0] mem [DEPTH];

    // Weight storage; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Gather one column: row r of column c lives at entry r*COLS + c.
    always_comb begin
        rd_word = '0;
        for (int r = 0; r < SIZE; r++) begin
            rd_word[r*CW +: CW] = mem[ADDR_W'(col_idx(r, int'(rd_col), COLS))];
        end
    end
endmodule

// File: rtl/compensation_buffer.sv
// Double-buffered compensation weight store: one bank loads while the other drains by column.
module compensation_buffer
    import comp_buf_pkg::*;
#(
    parameter int SIZE = 8,
    parameter int CW   = 3,
    parameter int COLS = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    compensation_buffer_if.slave   bus
);
    localparam int DEPTH  = SIZE * COLS;
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int COL_W  = idx_w(COLS);

    logic               wr_bank_q,   wr_bank_d;
    logic               rd_bank_q,   rd_bank_d;
    logic [ADDR_W-1:0]  wr_ptr_q,    wr_ptr_d;
    logic [1:0]         bank_full_q, bank_full_d;
    rd_state_e          state_q,     state_d;
    logic [COL_W-1:0]   col_q,       col_d;
    logic               out_valid_q, out_valid_d;
    logic [COL_W-1:0]   out_col_q,   out_col_d;
    logic [SIZE*CW-1:0] out_data_q,  out_data_d;

    logic               wr_accept;
    logic               set_full;
    logic               clr_full;
    logic [1:0]         bank_we;
    logic [SIZE*CW-1:0] bank_word [2];

    for (genvar b = 0; b < 2; b++) begin : g_bank
        comp_buf_bank #(
            .SIZE (SIZE),
            .CW   (CW),
            .COLS (COLS)
        ) u_bank (
            .clk     (clk),
            .we      (bank_we[b]),
            .waddr   (wr_ptr_q),
            .wdata   (bus.wr_data),
            .rd_col  (col_q),
            .rd_word (bank_word[b])
        );
    end

    // Next-state for the load pointer, bank flags and the drain FSM; flush wins over everything.
    always_comb begin
        wr_bank_d   = wr_bank_q;
        rd_bank_d   = rd_bank_q;
        wr_ptr_d    = wr_ptr_q;
        bank_full_d = bank_full_q;
        state_d     = state_q;
        col_d       = col_q;
        out_valid_d = 1'b0;
        out_col_d   = out_col_q;
        out_data_d  = out_data_q;
        set_full    = 1'b0;
        clr_full    = 1'b0;
        bank_we     = '0;

        wr_accept = bus.wr_valid && !bank_full_q[wr_bank_q];

        if (wr_accept) begin
            bank_we[wr_bank_q] = 1'b1;
            if (wr_ptr_q == ADDR_W'(DEPTH - 1)) begin
                wr_ptr_d               = '0;
                bank_full_d[wr_bank_q] = 1'b1;
                wr_bank_d              = ~wr_bank_q;
                set_full               = 1'b1;
            end else begin
                wr_ptr_d = wr_ptr_q + ADDR_W'(1);
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.rd_start && bank_full_q[rd_bank_q]) begin
                    state_d = ST_STREAM;
                    col_d   = '0;
                end
            end
            ST_STREAM: begin
                out_data_d  = bank_word[rd_bank_q];
                out_valid_d = 1'b1;
                out_col_d   = col_q;
                col_d       = col_q + COL_W'(1);
                if (col_q == COL_W'(COLS - 1)) begin
                    bank_full_d[rd_bank_q] = 1'b0;
                    rd_bank_d              = ~rd_bank_q;
                    state_d                = ST_IDLE;
                    col_d                  = '0;
                    clr_full               = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (bus.flush) begin
            wr_bank_d   = 1'b0;
            rd_bank_d   = 1'b0;
            wr_ptr_d    = '0;
            bank_full_d = 2'b00;
            state_d     = ST_IDLE;
            col_d       = '0;
            out_valid_d = 1'b0;
            out_col_d   = '0;
            out_data_d  = '0;
            bank_we     = '0;
        end
    end

    // Control and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            wr_ptr_q    <= '0;
            bank_full_q <= 2'b00;
            state_q     <= ST_IDLE;
            col_q       <= '0;
            out_valid_q <= 1'b0;
            out_col_q   <= '0;
            out_data_q  <= '0;
        end else begin
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            wr_ptr_q    <= wr_ptr_d;
            bank_full_q <= bank_full_d;
            state_q     <= state_d;
            col_q       <= col_d;
            out_valid_q <= out_valid_d;
            out_col_q   <= out_col_d;
            out_data_q  <= out_data_d;
        end
    end

    assign bus.wr_ready  = !bank_full_q[wr_bank_q];
    assign bus.rd_busy   = (state_q == ST_STREAM);
    assign bus.out_valid = out_valid_q;
    assign bus.out_col   = out_col_q;
    assign bus.out_data  = out_data_q;
    assign bus.bank_full = bank_full_q;

    // The drained bank is full and cannot be loaded, so a set and a clear never hit the same bank.
    a_no_flag_collision: assert property (@(posedge clk) disable iff (!rst_n)
        !(set_full && clr_full && (wr_bank_q == rd_bank_q)));
endmodule

// File: tb/tb_compensation_buffer.sv
// Scoreboard bench: tiles complete in load order and drain in the same order.
module tb_compensation_buffer;
    localparam int SIZE  = 8;
    localparam int CW    = 3;
    localparam int COLS  = 3;
    localparam int DEPTH = SIZE * COLS;

    typedef logic [DEPTH*CW-1:0] tile_t;
    typedef struct packed {
        int                 col;
        logic [SIZE*CW-1:0] data;
        int                 cyc;
    } exp_t;

    logic clk;
    logic rst_n;

    compensation_buffer_if #(.SIZE(SIZE), .CW(CW), .COLS(COLS)) bus ();

    compensation_buffer #(.SIZE(SIZE), .CW(CW), .COLS(COLS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    n_checks = 0;
    int    n_fail   = 0;
    int    tb_cyc   = 0;

    // Reference model state
    tile_t full_q[$];
    tile_t part;
    int    n_part    = 0;
    int    rd_idx    = 0;
    bit    streaming = 0;
    int    scnt      = 0;
    exp_t  exp_q[$];

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, tb_cyc);
        end
    endfunction

    function automatic logic [1:0] exp_flags();
        logic [1:0] f;
        f = 2'b00;
        for (int i = 0; i < full_q.size(); i++) f[(rd_idx + i) % 2] = 1'b1;
        return f;
    endfunction

    task automatic model_clear();
        full_q.delete();
        exp_q.delete();
        n_part    = 0;
        part      = '0;
        rd_idx    = 0;
        streaming = 0;
        scnt      = 0;
    endtask

    // Apply one clock edge to the model using the inputs presented before it.
    task automatic model_edge(input logic wv, input logic [CW-1:0] wd, input logic rs, input logic fl);
        bit    acc, rel, st;
        tile_t t;
        exp_t  e;
        if (fl) begin
            model_clear();
            return;
        end
        acc = wv && (full_q.size() < 2);
        rel = streaming && (scnt == COLS - 1);
        st  = !streaming && rs && (full_q.size() >= 1);
        if (st) begin
            t = full_q[0];
            for (int c = 0; c < COLS; c++) begin
                e.col  = c;
                e.data = '0;
                for (int r = 0; r < SIZE; r++) e.data[r*CW +: CW] = t[(r*COLS + c)*CW +: CW];
                e.cyc  = tb_cyc + 1 + c;
                exp_q.push_back(e);
            end
            streaming = 1;
            scnt      = 0;
        end else if (streaming) begin
            if (rel) streaming = 0;
            else     scnt++;
        end
        if (rel) begin
            full_q.delete(0);
            rd_idx ^= 1;
        end
        if (acc) begin
            part[n_part*CW +: CW] = wd;
            n_part++;
            if (n_part == DEPTH) begin
                full_q.push_back(part);
                n_part = 0;
            end
        end
    endtask

    // Present inputs for one cycle, check steady outputs, then advance the model at the edge.
    task automatic step(input logic wv, input logic [CW-1:0] wd, input logic rs, input logic fl);
        bus.wr_valid = wv;
        bus.wr_data  = wd;
        bus.rd_start = rs;
        bus.flush    = fl;
        chk("wr_ready", bus.wr_ready, full_q.size() < 2);
        chk("bank_full", bus.bank_full, exp_flags());
        chk("rd_busy", bus.rd_busy, streaming);
        @(posedge clk);
        tb_cyc++;
        model_edge(wv, wd, rs, fl);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic load_random(input int n);
        for (int i = 0; i < n; i++) step(1'b1, CW'($urandom), 1'b0, 1'b0);
    endtask

    // Monitor: compare every cycle's output against the scoreboard head.
    exp_t mon_e;
    bit   mon_v;
    always @(negedge clk) begin
        if (rst_n) begin
            while (exp_q.size() > 0 && exp_q[0].cyc < tb_cyc) begin
                n_checks++;
                n_fail++;
                $display("FAIL missed_column: col %0d expected at cycle %0d, now %0d",
                         exp_q[0].col, exp_q[0].cyc, tb_cyc);
                exp_q.delete(0);
            end
            mon_v = (exp_q.size() > 0) && (exp_q[0].cyc == tb_cyc);
            chk("out_valid", bus.out_valid, mon_v);
            if (mon_v) begin
                mon_e = exp_q.pop_front();
                if (bus.out_valid) begin
                    chk("out_col", bus.out_col, mon_e.col);
                    chk("out_data", bus.out_data, mon_e.data);
                end
            end
        end
    end

    initial begin
        rst_n        = 1'b0;
        bus.flush    = 1'b0;
        bus.wr_valid = 1'b0;
        bus.wr_data  = '0;
        bus.rd_start = 1'b0;
        part         = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_out_col", bus.out_col, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_rd_busy", bus.rd_busy, 1'b0);
        chk("rst_bank_full", bus.bank_full, 2'b00);
        chk("rst_wr_ready", bus.wr_ready, 1'b1);
        rst_n = 1'b1;

        // Linear pattern i%8, then a single drain.
        for (int i = 0; i < DEPTH; i++) step(1'b1, CW'(i % 8), 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        idle(5);

        // Fill both banks; the 49th beat must be refused.
        load_random(2 * DEPTH + 1);
        idle(2);
        step(1'b0, '0, 1'b1, 1'b0);
        idle(4);
        step(1'b0, '0, 1'b1, 1'b0);
        idle(5);

        // Ping-pong: drain one bank while the other loads continuously.
        load_random(DEPTH);
        for (int i = 0; i < DEPTH; i++) step(1'b1, CW'($urandom), (i == 0), 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        idle(5);

        // rd_start with nothing full, then rd_start held through a whole drain.
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        load_random(DEPTH);
        for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1, 1'b0);
        idle(3);

        // Asynchronous reset during the second stream cycle.
        load_random(DEPTH);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("async_out_valid", bus.out_valid, 1'b0);
        chk("async_bank_full", bus.bank_full, 2'b00);
        chk("async_rd_busy", bus.rd_busy, 1'b0);
        model_clear();
        repeat (2) begin
            @(posedge clk);
            tb_cyc++;
        end
        #1;
        rst_n = 1'b1;
        chk("post_rst_wr_ready", bus.wr_ready, 1'b1);
        idle(2);

        // Flush with a beat offered at pointer 5, then a clean reload and drain.
        load_random(5);
        step(1'b1, CW'($urandom), 1'b0, 1'b1);
        load_random(DEPTH);
        step(1'b0, '0, 1'b1, 1'b0);
        idle(5);

        // Flush in the middle of a drain.
        load_random(DEPTH);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1);
        idle(4);

        // Randomised mix of loads, drains and rare flushes.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 9) < 7), CW'($urandom), ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 99) < 2));
        end
        idle(6);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/compensation_buffer.md
Name: compensation_buffer

Overview:
- Parametrised, double-buffered successor to the compensation weight store feeding the systolic array.
- Holds two banks of SIZE x COLS compensation weights, each CW bits wide.
- The pre-load unit streams weights into one bank through a valid/ready handshake while the array drains the other bank, one column per cycle.
- Load and compute overlap, and no external addressing is required.

Parameters:
- SIZE, 8: array rows; one weight per row per column.
- CW, 3: compensation weight width in bits.
- COLS, 3: columns per bank tile.
- DEPTH, SIZE*COLS: entries per bank (derived, do not override).
- ADDR_W, $clog2(DEPTH): write pointer width (derived).
- COL_W, max(1,$clog2(COLS)): column index width (derived).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of all control state.
- wr_valid  in  1  write data valid.
- wr_ready  out  1  bank space available.
- wr_data  in  CW  compensation weight.
- rd_start  in  1  request drain of the next full bank.
- rd_busy  out  1  drain in progress.
- out_valid  out  1  out_data holds a column.
- out_col  out  COL_W  column index of out_data.
- out_data  out  SIZE*CW  column word; row r sits at bits [r*CW +: CW], row SIZE-1 at MSB.
- bank_full  out  2  per-bank full flags.

Behaviour:
- Storage: two banks of DEPTH x CW. Entry index = row*COLS + col.
  - Write order is linear 0..DEPTH-1, so column c = entries c, c+COLS, …, c+(SIZE-1)*COLS.
- Reset (rst_n low, async):
  - wr_bank=0, rd_bank=0, wr_ptr=0, bank_full=2'b00, FSM=IDLE.
  - out_valid=0, out_col=0, out_data=0, rd_busy=0.
  - Memory contents are not reset.
- flush (sync): same clears as reset. Overrides all same-cycle writes and reads.
- Write side:
  - wr_ready = !bank_full[wr_bank] (registered flags, no bypass).
  - On accept (wr_valid & wr_ready): store wr_data at mem[wr_bank][wr_ptr] and increment wr_ptr.
  - When accepting at wr_ptr==DEPTH-1: wr_ptr←0, bank_full[wr_bank]←1, wr_bank toggles.
  - wr_valid while !wr_ready: data dropped by the handshake; the producer must hold it.
- Read FSM, states IDLE and STREAM:
  - IDLE: rd_start & bank_full[rd_bank] → STREAM with col=0; rd_busy=1 from the next cycle.
  - IDLE: rd_start with the bank not full is ignored; no out_valid.
  - STREAM: each cycle, register column col of rd_bank into out_data, set out_valid=1, out_col=col, then col++.
  - Latency: first out_valid is 2 cycles after the accepted rd_start. Exactly COLS consecutive valid cycles, no gaps.
  - STREAM with col==COLS-1: bank_full[rd_bank]←0, rd_bank toggles, FSM→IDLE, rd_busy←0.
  - rd_start during STREAM is ignored; back-to-back drains need rd_start re-asserted in IDLE.
  - out_valid deasserts the cycle after the last column; out_data holds its last value.
- Simultaneous events:
  - Writer completing bank X while reader releases bank Y: both flag updates apply.
  - Reader releasing the bank the writer is stalled on: wr_ready rises the following cycle.
  - Flags set and clear for the same bank in the same cycle is impossible by construction, since the bank being drained is full and cannot accept writes. Verify this with an assertion.
- Reset or flush mid-STREAM: stream aborts, out_valid=0 the next cycle, and both banks are treated as empty.

Decomposition:
- Package comp_buf_pkg: read FSM state enum (ST_IDLE, ST_STREAM) and helper function col_idx(row,col,COLS).
- Sub-module comp_buf_bank: a single bank with one write port and one column-gather read port (SIZE parallel reads at stride COLS). Instantiated twice.

Test Plan:
- Defaults. Write 24 entries with value i%8, then rd_start → 2 cycles later 3 valid cycles: out_col 0,1,2; col0 word = rows {0,3,6,1,4,7,2,5}%8 packed with row 7 at MSB. Then bank_full=00.
- Write 48 entries with no reads → both flags 11, wr_ready=0 on the 49th beat, that beat's data not stored.
- Ping-pong: drain bank 0 while writing bank 1 continuously → wr_ready never drops. Second drain returns bank-1 data.
- rd_start with no full bank → out_valid stays 0, rd_busy 0. rd_start during STREAM → exactly 3 valid cycles.
- Assert rst_n low on the 2nd STREAM cycle → out_valid 0 asynchronously, bank_full=00, wr_ready=1 after release.
- flush with wr_valid asserted at wr_ptr=5 → wr_ptr=0, no write; a subsequent full load reads back correctly.
